// File: rtl/score_display_if.sv
// Bundle between the game controller and the score display back-end.
// The master side owns ball position and scores; the slave side (the
// display) owns the LED track, segment and digit-enable lines.
interface score_display_if;
    logic [7:0] position;
    logic [3:0] score_player1;
    logic [3:0] score_player2;
    logic [7:0] led;
    logic [7:0] seg;
    logic [3:0] dig_sel;

    modport master (
        output position,
        output score_player1,
        output score_player2,
        input  led,
        input  seg,
        input  dig_sel
    );

    modport slave (
        input  position,
        input  score_player1,
        input  score_player2,
        output led,
        output seg,
        output dig_sel
    );
endinterface

// File: rtl/score_display.sv
// Score display back-end: ball track LEDs plus a 4-digit multiplexed
// 7-segment scan (P1 on digits 3/2, P2 on digits 1/0). Scores are frozen
// once per frame so a frame never mixes two values, and a player sitting
// on 11 blinks at a rate of BLINK_FRAMES frames per half-period.
module score_display #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic           clk,
    input  logic           rst,
    score_display_if.slave bus
);

    // Slot timer is a down-counter: 0 is the dead-time phase, after which it
    // reloads to SCAN_DIV-1 and counts down; phase k maps to SCAN_DIV-k.
    localparam int          SW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LOAD = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(1);

    // Frame counter holds 0..BLINK_FRAMES; it counts frames since the last
    // blink toggle so the first BLINK_FRAMES frames after reset are lit.
    localparam int          FW        = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_TOP = FW'(BLINK_FRAMES);

    localparam logic [7:0] GLYPH_BLANK = 8'h00;
    localparam logic [7:0] GLYPH_DASH  = 8'h40;

    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [3:0]    snap1_q, snap1_d;
    logic [3:0]    snap2_q, snap2_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_on_q, blink_on_d;
    logic [7:0]    led_q, led_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    dig_sel_q, dig_sel_d;

    logic          dead_time;
    logic          frame_start;
    logic [3:0]    cur_score;
    logic          cur_is_tens;
    logic [7:0]    cur_glyph;
    logic          cur_blank;

    function automatic logic [7:0] digit_glyph(input logic [3:0] d);
        logic [7:0] g;
        g = GLYPH_DASH;
        case (d)
            4'd0: g = 8'h3F;
            4'd1: g = 8'h06;
            4'd2: g = 8'h5B;
            4'd3: g = 8'h4F;
            4'd4: g = 8'h66;
            4'd5: g = 8'h6D;
            4'd6: g = 8'h7D;
            4'd7: g = 8'h07;
            4'd8: g = 8'h7F;
            4'd9: g = 8'h6F;
            default: g = GLYPH_DASH;
        endcase
        return g;
    endfunction

    // Scan timing, per-frame snapshot and blink phase.
    always_comb begin
        slot_cnt_d  = slot_cnt_q;
        digit_d     = digit_q;
        snap1_d     = snap1_q;
        snap2_d     = snap2_q;
        frame_d     = frame_q;
        blink_on_d  = blink_on_q;

        dead_time   = (slot_cnt_q == '0);
        frame_start = dead_time && (digit_q == 2'd3);

        if (dead_time) begin
            slot_cnt_d = SLOT_LOAD;
        end else begin
            slot_cnt_d = slot_cnt_q - SW'(1);
        end

        // Digit index wraps 0 -> 3 naturally in two bits.
        if (slot_cnt_q == SLOT_LAST) begin
            digit_d = digit_q - 2'd1;
        end

        if (frame_start) begin
            snap1_d = bus.score_player1;
            snap2_d = bus.score_player2;
            if (frame_q == FRAME_TOP) begin
                frame_d    = FW'(1);
                blink_on_d = ~blink_on_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
    end

    // Output decode from the current slot and the frozen snapshots.
    always_comb begin
        led_d       = bus.position;
        seg_d       = GLYPH_BLANK;
        dig_sel_d   = 4'b1111;

        cur_score   = digit_q[1] ? snap1_q : snap2_q;
        cur_is_tens = digit_q[0];
        cur_glyph   = GLYPH_BLANK;

        if (cur_score > 4'd11) begin
            cur_glyph = GLYPH_DASH;
        end else if (cur_is_tens) begin
            cur_glyph = (cur_score >= 4'd10) ? digit_glyph(4'd1) : GLYPH_BLANK;
        end else if (cur_score >= 4'd10) begin
            cur_glyph = digit_glyph(cur_score - 4'd10);
        end else begin
            cur_glyph = digit_glyph(cur_score);
        end

        // Illegal scores never equal 11, so they are never blanked.
        cur_blank = (cur_score == 4'd11) && !blink_on_q;

        if (!dead_time) begin
            dig_sel_d = ~(4'b0001 << digit_q);
            seg_d     = cur_blank ? GLYPH_BLANK : cur_glyph;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q <= '0;
            digit_q    <= 2'd3;
            snap1_q    <= 4'd0;
            snap2_q    <= 4'd0;
            frame_q    <= '0;
            blink_on_q <= 1'b1;
            led_q      <= 8'h00;
            seg_q      <= 8'h00;
            dig_sel_q  <= 4'b1111;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            digit_q    <= digit_d;
            snap1_q    <= snap1_d;
            snap2_q    <= snap2_d;
            frame_q    <= frame_d;
            blink_on_q <= blink_on_d;
            led_q      <= led_d;
            seg_q      <= seg_d;
            dig_sel_q  <= dig_sel_d;
        end
    end

    assign bus.led     = led_q;
    assign bus.seg     = seg_q;
    assign bus.dig_sel = dig_sel_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with SCAN_DIV=4, BLINK_FRAMES=2.
// Each step drives one cycle of inputs, pushes the model's expected outputs
// into a queue, and after the edge pops and compares them.
module tb_score_display;

    localparam int SD = 4;
    localparam int BF = 2;

    typedef struct {
        logic [7:0] led;
        logic [7:0] seg;
        logic [3:0] dig;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    score_display_if bus ();

    score_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t       exp_q [$];
    int         errors = 0;
    int         checks = 0;
    int         n      = 0;
    logic [3:0] ms1    = 4'd0;
    logic [3:0] ms2    = 4'd0;
    logic [7:0] tbl [0:9];
    logic [7:0] last_led;
    logic [7:0] last_seg;
    logic [3:0] last_dig;

    function automatic logic [7:0] model_seg(input int digit, input logic [3:0] s,
                                             input bit blink_on);
        logic [7:0] g;
        if (s > 4'd11)               g = 8'h40;
        else if (s == 4'd11 && !blink_on) g = 8'h00;
        else if (digit % 2 == 1)     g = (s >= 4'd10) ? 8'h06 : 8'h00;
        else                         g = tbl[int'(s) % 10];
        return g;
    endfunction

    function automatic logic [7:0] rand_pos();
        int v;
        v = $urandom_range(0, 8);
        return (v == 0) ? 8'h00 : (8'h01 << (v - 1));
    endfunction

    task automatic step(input logic r, input logic [7:0] pos,
                        input logic [3:0] p1, input logic [3:0] p2);
        exp_t e;
        exp_t got;
        int   phase, digit, frame;
        bit   blink_on;
        rst               = r;
        bus.position      = pos;
        bus.score_player1 = p1;
        bus.score_player2 = p2;
        e.cyc = n;
        if (r) begin
            e.led = 8'h00;
            e.seg = 8'h00;
            e.dig = 4'b1111;
            n     = 0;
            ms1   = 4'd0;
            ms2   = 4'd0;
        end else begin
            phase    = n % SD;
            digit    = 3 - ((n / SD) % 4);
            frame    = n / (4 * SD);
            blink_on = ((frame / BF) % 2) == 0;
            if (phase == 0 && digit == 3) begin
                ms1 = p1;
                ms2 = p2;
            end
            e.led = pos;
            if (phase == 0) begin
                e.seg = 8'h00;
                e.dig = 4'b1111;
            end else begin
                e.dig        = 4'b1111;
                e.dig[digit] = 1'b0;
                e.seg        = model_seg(digit, (digit >= 2) ? ms1 : ms2, blink_on);
            end
            n++;
        end
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        got      = exp_q.pop_front();
        last_led = bus.led;
        last_seg = bus.seg;
        last_dig = bus.dig_sel;
        checks += 3;
        assert (bus.led === got.led) else begin
            errors++;
            $error("FAIL led cyc=%0d got=%h exp=%h", got.cyc, bus.led, got.led);
        end
        assert (bus.seg === got.seg) else begin
            errors++;
            $error("FAIL seg cyc=%0d got=%h exp=%h", got.cyc, bus.seg, got.seg);
        end
        assert (bus.dig_sel === got.dig) else begin
            errors++;
            $error("FAIL dig_sel cyc=%0d got=%b exp=%b", got.cyc, bus.dig_sel, got.dig);
        end
    endtask

    initial begin
        tbl[0] = 8'h3F; tbl[1] = 8'h06; tbl[2] = 8'h5B; tbl[3] = 8'h4F; tbl[4] = 8'h66;
        tbl[5] = 8'h6D; tbl[6] = 8'h7D; tbl[7] = 8'h07; tbl[8] = 8'h7F; tbl[9] = 8'h6F;
        rst               = 1'b1;
        bus.position      = 8'h00;
        bus.score_player1 = 4'd0;
        bus.score_player2 = 4'd0;
        #1;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) step(1'b1, rand_pos(), 4'd5, 4'd6);

        // Decode: P1=7, P2=10 over two frames.
        for (int i = 0; i < 32; i++) step(1'b0, rand_pos(), 4'd7, 4'd10);

        // Snapshot: P1 changes 3 -> 4 inside frame 0.
        step(1'b1, 8'h00, 4'd3, 4'd0);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, rand_pos(), (i < 6) ? 4'd3 : 4'd4, 4'd0);
            if (i == 7) begin
                checks++;
                assert (last_seg === 8'h4F) else begin
                    errors++;
                    $error("FAIL snap_hold got=%h exp=4f", last_seg);
                end
            end
            if (i == 21) begin
                checks++;
                assert (last_seg === 8'h66) else begin
                    errors++;
                    $error("FAIL snap_new got=%h exp=66", last_seg);
                end
            end
        end

        // Blink: P1 at 11, six frames.
        step(1'b1, 8'h00, 4'd11, 4'd5);
        for (int i = 0; i < 96; i++) begin
            step(1'b0, rand_pos(), 4'd11, 4'd5);
            if (i == 37) begin
                checks++;
                assert (last_seg === 8'h00 && last_dig === 4'b1011) else begin
                    errors++;
                    $error("FAIL blink_off got=%h/%b exp=00/1011", last_seg, last_dig);
                end
            end
        end

        // Illegal score on P2: dashes, never blanked.
        step(1'b1, 8'h00, 4'd0, 4'd13);
        for (int i = 0; i < 64; i++) step(1'b0, rand_pos(), 4'd11, 4'd13);

        // LED latency and reset in the middle of a frame.
        step(1'b1, 8'h00, 4'd2, 4'd3);
        for (int i = 0; i < 9; i++) step(1'b0, (i == 8) ? 8'h20 : rand_pos(), 4'd2, 4'd3);
        checks++;
        assert (last_led === 8'h20) else begin
            errors++;
            $error("FAIL led_lat got=%h exp=20", last_led);
        end
        step(1'b1, 8'h81, 4'd2, 4'd3);
        checks++;
        assert (last_led === 8'h00 && last_dig === 4'b1111) else begin
            errors++;
            $error("FAIL mid_rst got=%h/%b exp=00/1111", last_led, last_dig);
        end
        for (int i = 0; i < 20; i++) step(1'b0, rand_pos(), 4'd2, 4'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
